// File: rtl/bus_responder_pkg.sv
// rtl/bus_responder_pkg.sv - shared bus types, IO register map and status bit positions
package bus_responder_pkg;

  typedef logic [31:0] mem_addr_bus_t;
  typedef logic [7:0]  byte_bus_t;

  localparam mem_addr_bus_t IO_BASE      = 32'h0003_0000;
  localparam logic [1:0]    IO_SPACE_SEL = IO_BASE[17:16];
  localparam logic [15:0]   IO_TX_OFF    = 16'h0000;
  localparam logic [15:0]   IO_CTRL_OFF  = 16'h0004;
  localparam logic [15:0]   IO_CNT_OFF   = 16'h0008;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;

  typedef enum logic [2:0] {
    IO_NONE, IO_TX, IO_CTRL, IO_CNT0, IO_CNT1, IO_CNT2, IO_CNT3
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [15:0] off);
    case (off)
      IO_TX_OFF:          return IO_TX;
      IO_CTRL_OFF:        return IO_CTRL;
      IO_CNT_OFF:         return IO_CNT0;
      IO_CNT_OFF + 16'd1: return IO_CNT1;
      IO_CNT_OFF + 16'd2: return IO_CNT2;
      IO_CNT_OFF + 16'd3: return IO_CNT3;
      default:            return IO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_responder_byte_fifo.sv
// rtl/bus_responder_byte_fifo.sv - byte-wide TX FIFO; a push into a full FIFO is taken only alongside a pop
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? 8'h00 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - single-cycle byte RAM plus memory-mapped TX FIFO, halt and cycle-counter registers
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int          RAM_ADDR_WIDTH = 17,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] CYCLE_INIT     = 32'h0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ram_rw,
  input  logic [31:0]               ram_addr,
  input  logic [7:0]                ram_w_data,
  output logic [7:0]                ram_r_data,
  input  logic                      ld_en,
  input  logic [RAM_ADDR_WIDTH-1:0] ld_addr,
  input  logic [7:0]                ld_data,
  output logic [7:0]                io_tx_data,
  output logic                      io_tx_valid,
  input  logic                      io_tx_ready,
  output logic                      io_halt,
  output logic [7:0]                io_halt_code
);

  logic [7:0]  mem [2**RAM_ADDR_WIDTH];
  logic        is_io;
  io_reg_e     io_reg;
  logic        bus_wr;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic [31:0] cycle_cnt;
  logic [31:8] cnt_latch;
  logic [7:0]  status;
  logic [7:0]  rd_byte;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^ram_addr[31:18];

  assign is_io     = (ram_addr[17:16] == IO_SPACE_SEL);
  assign io_reg    = is_io ? io_decode(ram_addr[15:0]) : IO_NONE;
  // Preload owns the RAM port; halt freezes all bus-side state changes.
  assign bus_wr    = ram_rw && !ld_en && !io_halt;
  assign fifo_push = bus_wr && (io_reg == IO_TX);
  assign fifo_pop  = io_tx_valid && io_tx_ready;

  always_comb begin
    status                 = 8'h00;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_OVF_BIT]   = overflow;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (ram_w_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (io_tx_data)
  );

  assign io_tx_valid = !fifo_empty;

  always_comb begin
    rd_byte = 8'h00;
    if (!ram_rw) begin
      case (io_reg)
        IO_NONE: rd_byte = is_io ? 8'h00 : mem[ram_addr[RAM_ADDR_WIDTH-1:0]];
        IO_CTRL: rd_byte = status;
        IO_CNT0: rd_byte = cycle_cnt[7:0];
        IO_CNT1: rd_byte = cnt_latch[15:8];
        IO_CNT2: rd_byte = cnt_latch[23:16];
        IO_CNT3: rd_byte = cnt_latch[31:24];
        default: rd_byte = 8'h00;
      endcase
    end
  end

  // RAM keeps its contents through reset, but nothing is written while reset is high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (ld_en)
        mem[ld_addr] <= ld_data;
      else if (bus_wr && !is_io)
        mem[ram_addr[RAM_ADDR_WIDTH-1:0]] <= ram_w_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_r_data   <= 8'h00;
      io_halt      <= 1'b0;
      io_halt_code <= 8'h00;
      overflow     <= 1'b0;
      cycle_cnt    <= CYCLE_INIT;
      cnt_latch    <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      ram_r_data <= rd_byte;
      if (!ram_rw && io_reg == IO_CNT0) cnt_latch <= cycle_cnt[31:8];
      if (bus_wr && io_reg == IO_CTRL) begin
        io_halt      <= 1'b1;
        io_halt_code <= ram_w_data;
      end
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

endmodule
